datapath: RTL and testbench
===========================

DATAPATH -- requirements
Module: datapath

Interface
REQ-001 SHALL have ports (name dir width meaning), clock and reset first: clk in 1 rising-edge clock; rst_n in 1 async active-low reset.
REQ-002 SHALL have control inputs, all 1 bit unless noted:
- SelectIns: IR load / fetch enable.
- RegWrite: register-file write.
- RegDst: write-address select; 0=rt, 1=rd.
- ALUSrcA: 0=PC, 1=A.
- ALUSrcB in 2: 0=B, 1=const 1, 2=sign-ext imm, 3=zero-ext imm.
- MemWrite: data-memory write.
- MemtoReg: write-back data; 0=ALUOut, 1=MDR.
- BEQ: branch enable.
- PCSrc in 2: 0=ALU result, 1=ALUOut, 2=jump target, 3=hold.
REQ-003 SHALL have instruction-load ports: imem_we in 1 write strobe; imem_addr in 8 word address; imem_wdata in 32 word.
REQ-004 SHALL have observation outputs: pc out 32; ir out 32; alu_result out 32 (combinational ALU output); zero out 1 (alu_result==0).

Function
REQ-005 SHALL be 32-bit data, 32x32 register file with r0 always reading 0; 256-word instruction memory and 256-word data memory, both word-addressed by [7:0].
REQ-006 SHALL decode IR fields as: op[31:26], rs[25:21], rt[20:16], rd[15:11], imm[15:0], funct[5:0], jaddr[25:0].
REQ-007 SHALL load every clock: A<=rf[rs], B<=rf[rt], ALUOut<=alu_result, MDR<=dmem[ALUOut[7:0]].
REQ-008 SHALL load IR<=imem[PC[7:0]] on a clock edge only when SelectIns=1.
REQ-009 SHALL select the ALU operation as follows:
- ALUSrcA=0: add.
- else BEQ=1: sub.
- else op=0: funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A signed slt (result 1/0); any other funct add.
- else op 0x0C: and; op 0x0D: or; any other op: add.
REQ-010 SHALL use PC sources: PCSrc=0 alu_result; 1 ALUOut; 2 {PC[31:26],jaddr}.
REQ-011 SHALL load PC when any of:
- SelectIns=1 and PCSrc!=3;
- PCSrc=2;
- BEQ=1, zero=1 and PCSrc=1.
PCSrc=3 SHALL always hold PC.
REQ-012 SHALL, when RegWrite=1 and the write address is non-zero, write rf[RegDst?rd:rt] <= (MemtoReg?MDR:ALUOut) at the clock edge; writes to r0 SHALL be discarded.
REQ-013 SHALL write dmem[ALUOut[7:0]]<=B at the clock edge when MemWrite=1.
REQ-014 SHALL make register/memory writes visible to A/B/MDR on the following edge (no bypass).
REQ-015 SHALL write imem[imem_addr]<=imem_wdata on the clock edge when imem_we=1, independent of rst_n.
REQ-016 SHALL let a simultaneous IR load and imem write to the same address return the old word.
REQ-017 SHALL wrap address arithmetic modulo 2^32; memory indices SHALL use the low 8 bits only.

Reset
REQ-018 SHALL, while rst_n=0, asynchronously clear PC, IR, A, B, ALUOut, MDR and all 32 registers to 0.
REQ-019 SHALL leave data and instruction memory contents unaffected by reset.
REQ-020 SHALL ignore all control inputs while rst_n=0; the first edge after release SHALL act normally.

Configuration
REQ-021 SHALL support macro DATAPATH_DBG_EN.
- Defined: adds input dbg_addr (5 bits) and output dbg_data (32 bits) = rf[dbg_addr], combinational, with r0 reading 0.
- Undefined: both ports are absent and behaviour is otherwise identical.

Structure
REQ-022 SHALL place in a shared package: ALUSrcB, PCSrc and ALU-operation encodings; funct/opcode constants; data width 32; memory depth 256.
REQ-023 SHALL implement the ALU as one sub-module named datapath_alu (a, b, op -> result, zero); all other logic SHALL be in datapath.

Verification
REQ-024 Reset: pulse rst_n low mid-run -> pc=0, ir=0, and all registers 0 (dbg read) immediately, without waiting for a clock edge.
REQ-025 Fetch: imem[0]=0x20010005; one cycle with SelectIns=1, ALUSrcA=0, ALUSrcB=1, PCSrc=0 -> pc=1, ir=0x20010005.
REQ-026 addi: decode cycle, then ALUSrcA=1/ALUSrcB=2 cycle, then RegWrite=1/RegDst=0/MemtoReg=0 -> r1=5.
REQ-027 R-type: r1=5, r2=7, sub r3,r1,r2 (ALUSrcA=1, ALUSrcB=0, then RegDst=1 write) -> r3=0xFFFFFFFE; slt gives r3=1.
REQ-028 Memory: sw r1,4(r0) with MemWrite -> dmem[4]=5; then lw r4,4(r0) with MemtoReg=1 -> r4=5.
REQ-029 Branch:
- beq r1,r1,+3 fetched at PC 4: decode computes ALUOut=8; BEQ=1, PCSrc=1 -> pc=8.
- With r1!=r2: pc stays 5.
- PCSrc=3 with SelectIns=1: pc unchanged.

Source files
------------

// File: rtl/datapath_pkg.sv
// datapath_pkg: shared widths, control/ALU encodings and opcode constants for datapath
package datapath_pkg;
    localparam int DW = 32;
    localparam int AW = 8;
    localparam int MEM_DEPTH = 256;

    typedef enum logic [1:0] {SRCB_B, SRCB_ONE, SRCB_SEXT, SRCB_ZEXT} srcb_e;
    typedef enum logic [1:0] {PC_ALU, PC_ALUOUT, PC_JUMP, PC_HOLD} pcsrc_e;
    typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    // PC-relative work always adds; BEQ forces a compare; otherwise decode op/funct
    function automatic alu_op_e alu_dec(input logic src_a, input logic beq,
                                        input logic [5:0] op, input logic [5:0] funct);
        return !src_a ? ALU_ADD :
               beq ? ALU_SUB :
               op == OP_RTYPE ? (funct == FN_ADD ? ALU_ADD :
                                 funct == FN_SUB ? ALU_SUB :
                                 funct == FN_AND ? ALU_AND :
                                 funct == FN_OR  ? ALU_OR  :
                                 funct == FN_SLT ? ALU_SLT : ALU_ADD) :
               op == OP_ANDI ? ALU_AND :
               op == OP_ORI ? ALU_OR : ALU_ADD;
    endfunction
endpackage

// File: rtl/datapath_if.sv
// datapath_if: control, instruction-load and observation bundle between controller and datapath
interface datapath_if;
    import datapath_pkg::*;
    logic            SelectIns, RegWrite, RegDst, ALUSrcA, MemWrite, MemtoReg, BEQ;
    logic [1:0]      ALUSrcB, PCSrc;
    logic            imem_we;
    logic [AW-1:0]   imem_addr;
    logic [DW-1:0]   imem_wdata;
    logic [DW-1:0]   pc, ir, alu_result;
    logic            zero;

    modport master (output SelectIns, RegWrite, RegDst, ALUSrcA, ALUSrcB, MemWrite, MemtoReg,
                           BEQ, PCSrc, imem_we, imem_addr, imem_wdata,
                    input  pc, ir, alu_result, zero);
    modport slave  (input  SelectIns, RegWrite, RegDst, ALUSrcA, ALUSrcB, MemWrite, MemtoReg,
                           BEQ, PCSrc, imem_we, imem_addr, imem_wdata,
                    output pc, ir, alu_result, zero);
endinterface

// File: rtl/datapath_alu.sv
// datapath_alu: combinational 32-bit ALU (add/sub/and/or/signed slt) with zero flag
module datapath_alu
    import datapath_pkg::*;
(
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  alu_op_e       op,
    output logic [DW-1:0] result,
    output logic          zero
);
    always_comb begin
        result = op == ALU_SUB ? a - b :
                 op == ALU_AND ? a & b :
                 op == ALU_OR  ? a | b :
                 op == ALU_SLT ? {{(DW-1){1'b0}}, $signed(a) < $signed(b)} : a + b;
        zero = result == '0;
    end
endmodule

// File: rtl/datapath.sv
// datapath: multicycle 32-bit datapath with register file, instruction and data memories.
// Define DATAPATH_DBG_EN to add the dbg_addr/dbg_data register-file read port.
module datapath
    import datapath_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    datapath_if.slave     bus
`ifdef DATAPATH_DBG_EN
    ,
    input  logic [4:0]    dbg_addr,
    output logic [DW-1:0] dbg_data
`endif
);
    logic [DW-1:0] pc_q, pc_d, ir_q, ir_d, a_q, a_d, b_q, b_d;
    logic [DW-1:0] alu_out_q, alu_out_d, mdr_q, mdr_d;
    logic [DW-1:0] rf_q [32];
    logic [DW-1:0] rf_d [32];
    logic [DW-1:0] imem [MEM_DEPTH];
    logic [DW-1:0] dmem [MEM_DEPTH];
    logic [DW-1:0] alu_a, alu_b, alu_result, wb_data;
    logic [4:0]    rs, rt, rd, wa;
    logic [15:0]   imm;
    alu_op_e       alu_op;
    logic          zero, pc_ld;

    assign rs  = ir_q[25:21];
    assign rt  = ir_q[20:16];
    assign rd  = ir_q[15:11];
    assign imm = ir_q[15:0];

    always_comb begin
        alu_a = bus.ALUSrcA ? a_q : pc_q;
        alu_b = bus.ALUSrcB == SRCB_B    ? b_q :
                bus.ALUSrcB == SRCB_ONE  ? {{(DW-1){1'b0}}, 1'b1} :
                bus.ALUSrcB == SRCB_SEXT ? {{16{imm[15]}}, imm} : {16'd0, imm};
        alu_op = alu_dec(bus.ALUSrcA, bus.BEQ, ir_q[31:26], ir_q[5:0]);
        // HOLD never loads; a jump loads even without a fetch
        pc_ld = (bus.SelectIns && bus.PCSrc != PC_HOLD) || bus.PCSrc == PC_JUMP ||
                (bus.BEQ && zero && bus.PCSrc == PC_ALUOUT);
        pc_d = !pc_ld ? pc_q :
               bus.PCSrc == PC_ALU    ? alu_result :
               bus.PCSrc == PC_ALUOUT ? alu_out_q : {pc_q[31:26], ir_q[25:0]};
        ir_d      = bus.SelectIns ? imem[pc_q[AW-1:0]] : ir_q;
        a_d       = rf_q[rs];
        b_d       = rf_q[rt];
        alu_out_d = alu_result;
        mdr_d     = dmem[alu_out_q[AW-1:0]];
        wa        = bus.RegDst ? rd : rt;
        wb_data   = bus.MemtoReg ? mdr_q : alu_out_q;
        rf_d      = rf_q;
        if (bus.RegWrite && wa != 5'd0) rf_d[wa] = wb_data;
    end

    // dmem lives here so that reset also blocks its write strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= '0;
            ir_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            alu_out_q <= '0;
            mdr_q     <= '0;
            rf_q      <= '{default: '0};
        end else begin
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            a_q       <= a_d;
            b_q       <= b_d;
            alu_out_q <= alu_out_d;
            mdr_q     <= mdr_d;
            rf_q      <= rf_d;
            if (bus.MemWrite) dmem[alu_out_q[AW-1:0]] <= b_q;
        end
    end

    always_ff @(posedge clk) begin
        if (bus.imem_we) imem[bus.imem_addr] <= bus.imem_wdata;
    end

    datapath_alu u_alu (
        .a      (alu_a),
        .b      (alu_b),
        .op     (alu_op),
        .result (alu_result),
        .zero   (zero)
    );

    assign bus.pc         = pc_q;
    assign bus.ir         = ir_q;
    assign bus.alu_result = alu_result;
    assign bus.zero       = zero;

`ifdef DATAPATH_DBG_EN
    assign dbg_data = dbg_addr == 5'd0 ? '0 : rf_q[dbg_addr];
`endif
endmodule

// File: tb/tb_datapath.sv
// tb_datapath: drives multicycle control sequences per instruction and checks against an ISA-level model
module tb_datapath;
    logic clk, rst_n;
    datapath_if bus();
`ifdef DATAPATH_DBG_EN
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;
`endif

    datapath dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
`ifdef DATAPATH_DBG_EN
        ,
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
`endif
    );

    int          n_chk, n_fail;
    logic [31:0] mrf [32];
    logic [31:0] mdm [256];
    logic [31:0] mpc;
    logic [7:0]  written [$];

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ctl(input logic sel, input logic rw, input logic rdst, input logic srca,
                       input logic [1:0] srcb, input logic mw, input logic m2r,
                       input logic beq, input logic [1:0] pcs);
        bus.SelectIns = sel;  bus.RegWrite = rw;  bus.RegDst = rdst;  bus.ALUSrcA = srca;
        bus.ALUSrcB = srcb;   bus.MemWrite = mw;  bus.MemtoReg = m2r; bus.BEQ = beq;
        bus.PCSrc = pcs;
    endtask

    task automatic idle();
        ctl(0, 0, 0, 0, 2'd0, 0, 0, 0, 2'd3);
    endtask

    task automatic imem_load(input logic [7:0] a, input logic [31:0] w);
        bus.imem_we = 1; bus.imem_addr = a; bus.imem_wdata = w;
        tick();
        bus.imem_we = 0;
    endtask

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'd0, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] ref_result(input logic [31:0] w, input logic [31:0] av,
                                               input logic [31:0] bv);
        logic [31:0] sx, zx;
        sx = {{16{w[15]}}, w[15:0]};
        zx = {16'd0, w[15:0]};
        case (w[31:26])
            6'h00: case (w[5:0])
                6'h22:   return av - bv;
                6'h24:   return av & bv;
                6'h25:   return av | bv;
                6'h2A:   return ($signed(av) < $signed(bv)) ? 32'd1 : 32'd0;
                default: return av + bv;
            endcase
            6'h0C:   return av & zx;
            6'h0D:   return av | zx;
            default: return av + sx;
        endcase
    endfunction

    task automatic wr(input logic [4:0] r, input logic [31:0] v);
        if (r != 5'd0) mrf[r] = v;
    endtask

    task automatic fetch(input logic [31:0] w, input bit clash);
        ctl(1, 0, 0, 0, 2'd1, 0, 0, 0, 2'd0);
        if (clash) begin
            bus.imem_we = 1; bus.imem_addr = mpc[7:0]; bus.imem_wdata = ~w;
        end
        tick();
        bus.imem_we = 0;
        mpc = mpc + 1;
        chk("fetch pc", bus.pc, mpc);
        chk("fetch ir", bus.ir, w);
    endtask

    task automatic run_instr(input logic [31:0] w, input bit pre, input bit clash);
        logic [5:0]  op;
        logic [31:0] av, bv, sx;
        logic [7:0]  addr;
        op = w[31:26];
        av = mrf[w[25:21]];
        bv = mrf[w[20:16]];
        sx = {{16{w[15]}}, w[15:0]};
        addr = 8'(av + sx);
        if (!pre) imem_load(mpc[7:0], w);
        fetch(w, clash);
        ctl(0, 0, 0, 0, 2'd2, 0, 0, 0, 2'd3);
        tick();
        if (op == 6'h04) begin
            ctl(0, 0, 0, 1, 2'd0, 0, 0, 1, 2'd1);
            #1;
            chk("beq zero", {31'd0, bus.zero}, {31'd0, av == bv});
            tick();
            if (av == bv) mpc = mpc + sx;
            chk("beq pc", bus.pc, mpc);
        end else if (op == 6'h2B) begin
            ctl(0, 0, 0, 1, 2'd2, 0, 0, 0, 2'd3);
            tick();
            ctl(0, 0, 0, 1, 2'd2, 1, 0, 0, 2'd3);
            tick();
            mdm[addr] = bv;
            written.push_back(addr);
        end else if (op == 6'h23) begin
            ctl(0, 0, 0, 1, 2'd2, 0, 0, 0, 2'd3);
            tick();
            tick();
            ctl(0, 1, 0, 0, 2'd0, 0, 1, 0, 2'd3);
            tick();
            wr(w[20:16], mdm[addr]);
        end else begin
            ctl(0, 0, 0, 1, op == 6'h00 ? 2'd0 : op == 6'h08 ? 2'd2 : 2'd3, 0, 0, 0, 2'd3);
            tick();
            ctl(0, 1, op == 6'h00, 0, 2'd0, 0, 0, 0, 2'd3);
            tick();
            wr(op == 6'h00 ? w[15:11] : w[20:16], ref_result(w, av, bv));
        end
        idle();
    endtask

    task automatic probe(input logic [4:0] r);
        logic [31:0] w;
        w = itype(6'h0D, r, 5'd0, 16'd0);
        imem_load(mpc[7:0], w);
        fetch(w, 0);
        ctl(0, 0, 0, 0, 2'd2, 0, 0, 0, 2'd3);
        tick();
        ctl(0, 0, 0, 1, 2'd3, 0, 0, 0, 2'd3);
        #1;
        chk($sformatf("reg r%0d", r), bus.alu_result, mrf[r]);
`ifdef DATAPATH_DBG_EN
        dbg_addr = r;
        #1;
        chk($sformatf("dbg r%0d", r), dbg_data, mrf[r]);
`endif
        tick();
        idle();
    endtask

    task automatic model_reset();
        mpc = 0;
        for (int i = 0; i < 32; i++) mrf[i] = 0;
    endtask

    initial begin
        logic [31:0] wz;
        n_chk = 0; n_fail = 0;
        bus.imem_we = 0; bus.imem_addr = 0; bus.imem_wdata = 0;
`ifdef DATAPATH_DBG_EN
        dbg_addr = 0;
`endif
        idle();
        model_reset();
        rst_n = 1;
        #1 rst_n = 0;
        imem_load(8'd0, itype(6'h08, 5'd0, 5'd1, 16'd5));
        chk("reset pc", bus.pc, 32'd0);
        chk("reset ir", bus.ir, 32'd0);
        chk("reset alu", bus.alu_result, 32'd0);
        chk("reset zero", {31'd0, bus.zero}, 32'd1);
        #3 rst_n = 1;

        run_instr(itype(6'h08, 5'd0, 5'd1, 16'd5), 1, 0);
        probe(5'd1);
        run_instr(itype(6'h08, 5'd0, 5'd2, 16'd7), 0, 0);
        probe(5'd2);
        run_instr(rtype(5'd1, 5'd2, 5'd3, 6'h22), 0, 0);
        probe(5'd3);
        run_instr(rtype(5'd1, 5'd2, 5'd3, 6'h2A), 0, 0);
        probe(5'd3);
        run_instr(itype(6'h2B, 5'd0, 5'd1, 16'd4), 0, 0);
        run_instr(itype(6'h23, 5'd0, 5'd4, 16'd4), 0, 0);
        probe(5'd4);
        run_instr(itype(6'h2B, 5'd0, 5'd1, 16'd0), 0, 0);
        run_instr(itype(6'h08, 5'd0, 5'd0, 16'd9), 0, 0);
        probe(5'd0);
        run_instr(itype(6'h0D, 5'd1, 5'd5, 16'h00F0), 0, 1);
        probe(5'd5);

        imem_load(mpc[7:0], {6'h02, 26'h30});
        fetch({6'h02, 26'h30}, 0);
        ctl(0, 0, 0, 0, 2'd0, 0, 0, 0, 2'd2);
        tick();
        mpc = {mpc[31:26], 26'h30};
        chk("jump pc", bus.pc, mpc);
        wz = itype(6'h08, 5'd0, 5'd6, 16'h1234);
        imem_load(mpc[7:0], wz);
        ctl(1, 0, 0, 0, 2'd1, 0, 0, 0, 2'd3);
        tick();
        chk("hold pc", bus.pc, mpc);
        chk("hold ir", bus.ir, wz);
        idle();

        @(posedge clk);
        #2 rst_n = 0;
        #1;
        chk("midreset pc", bus.pc, 32'd0);
        chk("midreset ir", bus.ir, 32'd0);
`ifdef DATAPATH_DBG_EN
        for (int i = 0; i < 32; i++) begin
            dbg_addr = 5'(i);
            #1;
            chk($sformatf("midreset r%0d", i), dbg_data, 32'd0);
        end
`endif
        ctl(1, 1, 1, 1, 2'd1, 1, 1, 1, 2'd0);
        bus.imem_we = 1; bus.imem_addr = 8'd0; bus.imem_wdata = itype(6'h08, 5'd0, 5'd1, 16'd5);
        tick();
        bus.imem_we = 0;
        tick();
        chk("reset hold pc", bus.pc, 32'd0);
        chk("reset hold ir", bus.ir, 32'd0);
        idle();
        model_reset();
        #2 rst_n = 1;

        run_instr(itype(6'h08, 5'd0, 5'd1, 16'd5), 1, 0);
        run_instr(itype(6'h08, 5'd0, 5'd2, 16'd7), 0, 0);
        run_instr(itype(6'h23, 5'd0, 5'd4, 16'd0), 0, 0);
        run_instr(itype(6'h08, 5'd0, 5'd0, 16'd9), 0, 0);
        run_instr(itype(6'h04, 5'd1, 5'd1, 16'd3), 0, 0);
        chk("beq taken target", bus.pc, 32'd8);
        run_instr(itype(6'h04, 5'd1, 5'd2, 16'd3), 0, 0);
        probe(5'd1);
        probe(5'd3);
        probe(5'd4);

        for (int k = 0; k < 40; k++) begin
            int          kind;
            logic [4:0]  rs, rt, rd;
            logic [15:0] imm;
            logic [31:0] w;
            logic [5:0]  fn;
            kind = $urandom_range(0, 9);
            rs = 5'($urandom_range(0, 7));
            rt = 5'($urandom_range(0, 7));
            rd = 5'($urandom_range(0, 7));
            imm = 16'($urandom);
            case ($urandom_range(0, 5))
                0: fn = 6'h20;
                1: fn = 6'h22;
                2: fn = 6'h24;
                3: fn = 6'h25;
                4: fn = 6'h2A;
                default: fn = 6'h27;
            endcase
            case (kind)
                1: w = itype(6'h08, rs, rt, imm);
                2: w = itype(6'h0C, rs, rt, imm);
                3: w = itype(6'h0D, rs, rt, imm);
                4: w = itype(6'h2B, rs, rt, imm);
                5: w = itype(6'h23, 5'd0, rt, {8'd0, written[$urandom_range(0, written.size() - 1)]});
                6: w = itype(6'h04, rs, ($urandom_range(0, 1) == 1) ? rs : rt,
                             16'($urandom_range(0, 15)) - 16'd8);
                default: w = rtype(rs, rt, rd, fn);
            endcase
            run_instr(w, 0, 0);
            if (kind != 4 && kind != 6) probe(w[31:26] == 6'h00 ? w[15:11] : w[20:16]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
